// File: rtl/mem_stream_pkg.sv
// Shared types and default widths for the row streamer.
// FSM encoding, word geometry and output buffer depth.
package mem_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int ELEMENT_W = 64;
   localparam int ADDR_W    = 20;
   localparam int UNITS     = 8;
   localparam int WORD_W    = UNITS * ELEMENT_W;

   localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer for streamed rows.
// Entry 0 is always the head; a pop shifts entry 1 down.
module stream_fifo2
   import mem_stream_pkg::*;
#(
   parameter int W = WORD_W + 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic         do_pop;
   logic         do_push;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count < FIFO_DEPTH) || do_pop);
   assign head    = e0;

   // Storage and occupancy; simultaneous push and pop keep count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         unique case (1'b1)
            do_push && do_pop: begin
               if (count == FIFO_DEPTH) begin
                  e0 <= e1;
                  e1 <= push_data;
               end else begin
                  e0 <= push_data;
               end
            end
            do_push && !do_pop: begin
               if (count == 2'd0) e0 <= push_data;
               else               e1 <= push_data;
               count <= count + 2'd1;
            end
            do_pop && !do_push: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mem_row_streamer.sv
// Walks a row range of the vector memory and streams each row.
// MEM_ROW_STREAMER_WRITE_BYPASS_EN adds same-cycle write forwarding.
module mem_row_streamer
   import mem_stream_pkg::*;
#(
   parameter int element_width          = ELEMENT_W,
   parameter int memories_address_width = ADDR_W,
   parameter int no_of_units            = UNITS
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic                                    start,
   input  logic [memories_address_width-1:0]       base_address,
   input  logic [memories_address_width-1:0]       length,
   output logic [memories_address_width-1:0]       read_address,
   input  logic [no_of_units*element_width-1:0]    memory_output,
`ifdef MEM_ROW_STREAMER_WRITE_BYPASS_EN
   input  logic                                    write_enable,
   input  logic [memories_address_width-1:0]       input_write_address,
   input  logic [no_of_units*element_width-1:0]    input_data,
`endif
   output logic [no_of_units*element_width-1:0]    out_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    finish
);

   localparam int AW = memories_address_width;
   localparam int WW = no_of_units * element_width;
   localparam logic [AW-1:0] ONE = AW'(1);

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] remaining;
   logic [AW-1:0] addr_q;
   logic [1:0]    count;
   logic [WW:0]   head;
   logic [WW-1:0] row_in;
   logic          pop;
   logic          issue;

   assign pop   = out_valid && out_ready;
   assign issue = (state == ISSUE) && ((count < FIFO_DEPTH) || pop);

`ifdef MEM_ROW_STREAMER_WRITE_BYPASS_EN
   assign row_in = (write_enable && (input_write_address == read_address))
                 ? input_data : memory_output;
`else
   assign row_in = memory_output;
`endif

   assign read_address = (state == ISSUE) ? rd_ptr : addr_q;
   assign out_valid    = (count != 2'd0);
   assign out_data     = head[WW-1:0];
   assign out_last     = out_valid && head[WW];
   assign busy         = (state == ISSUE) || (state == DRAIN);
   assign finish       = (state == DONE);

   // Row buffer between the memory read port and the consumer.
   stream_fifo2 #(.W(WW + 1)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (issue),
      .push_data ({remaining == ONE, row_in}),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Pass pointers; addr_q keeps the last driven address outside ISSUE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         remaining <= '0;
         addr_q    <= '0;
      end else begin
         if (state == IDLE && start) begin
            rd_ptr    <= base_address;
            remaining <= length;
         end else if (issue) begin
            rd_ptr    <= rd_ptr + ONE;
            remaining <= remaining - ONE;
         end
         if (state == ISSUE) addr_q <= rd_ptr;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start) state_n = (length == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            if (issue && remaining == ONE) state_n = DRAIN;
         end
         DRAIN: begin
            if (count == 2'd0) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_row_streamer.sv
// Scoreboard bench for mem_row_streamer.
// Memory model returns row k = {8{k}} unless overwritten.
module tb_mem_row_streamer;

   localparam int AW = 20;
   localparam int WW = 512;

   logic          clk = 0;
   logic          reset_n = 0;
   logic          start = 0;
   logic [AW-1:0] base_address = '0;
   logic [AW-1:0] length = '0;
   logic [AW-1:0] read_address;
   logic [WW-1:0] memory_output;
   logic [WW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1;
   logic          out_last;
   logic          busy;
   logic          finish;

   logic          write_enable;
   logic [AW-1:0] input_write_address;
   logic [WW-1:0] input_data;
   logic          wr_arm = 0;
   logic          ov_valid = 0;
   logic [AW-1:0] ov_addr = '0;
   logic [WW-1:0] ov_data = '0;

   logic [WW:0]   exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            fin_cnt = 0;
   bit            busy_seen = 0;
   bit            prev_stall = 0;
   logic [WW-1:0] prev_data = '0;
   bit            toggle_mode = 0;
   bit            bypass_mode = 0;

   always #5 clk = ~clk;

   function automatic logic [WW-1:0] row_of(input logic [AW-1:0] k);
      logic [63:0] e;
      e = {44'd0, k};
      return {8{e}};
   endfunction

   function automatic logic [WW-1:0] a5_row();
      logic [63:0] e;
      e = 64'hA5;
      return {8{e}};
   endfunction

   assign memory_output = (ov_valid && read_address == ov_addr)
                        ? ov_data : row_of(read_address);
   assign write_enable        = wr_arm && busy && (read_address == 20'd6);
   assign input_write_address = read_address;
   assign input_data          = a5_row();

   always @(posedge clk) begin
      if (write_enable) begin
         ov_valid <= 1'b1;
         ov_addr  <= input_write_address;
         ov_data  <= input_data;
      end
   end

   mem_row_streamer dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .base_address        (base_address),
      .length              (length),
      .read_address        (read_address),
      .memory_output       (memory_output),
`ifdef MEM_ROW_STREAMER_WRITE_BYPASS_EN
      .write_enable        (write_enable),
      .input_write_address (input_write_address),
      .input_data          (input_data),
`endif
      .out_data            (out_data),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_last            (out_last),
      .busy                (busy),
      .finish              (finish)
   );

   // out_ready driver: held high or cycling 1,0,0,1,0,1.
   initial begin
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int idx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_mode) begin
            out_ready = pat[idx];
            idx = (idx + 1) % 6;
         end else begin
            out_ready = 1'b1;
            idx = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted beat.
   always @(negedge clk) begin
      logic [WW:0] e;
      if (!reset_n) begin
         prev_stall = 0;
      end else begin
         if (busy) busy_seen = 1;
         if (finish) begin
            fin_cnt++;
            checks++;
            if (busy) begin
               errors++;
               $display("FAIL finish_busy: busy=%b with finish, want 0", busy);
            end
         end
         if (prev_stall) begin
            checks++;
            if (!out_valid || out_data !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h want %h",
                        out_valid, out_data[63:0], prev_data[63:0]);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got data %h, want no beat",
                        out_data[63:0]);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e[WW-1:0] || out_last !== e[WW]) begin
                  errors++;
                  $display("FAIL beat: got %h last=%b want %h last=%b",
                           out_data[63:0], out_last, e[63:0], e[WW]);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
      @(posedge clk);
      #1;
      base_address = b;
      length = n;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic push_exp(input logic [AW-1:0] b, input logic [AW-1:0] n);
      logic [AW-1:0] k;
      logic [WW-1:0] d;
      for (int i = 0; i < int'(n); i++) begin
         k = b + AW'(i);
         d = (bypass_mode && k == 20'd6) ? a5_row() : row_of(k);
         exp_q.push_back({(i == int'(n) - 1), d});
      end
   endtask

   task automatic run_pass(input string name, input logic [AW-1:0] b,
                           input logic [AW-1:0] n);
      int f0;
      bit got;
      push_exp(b, n);
      busy_seen = 0;
      f0 = fin_cnt;
      got = 0;
      pulse_start(b, n);
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (fin_cnt != f0) got = 1;
      end
      if (!got) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: no finish within 200 cycles", name);
      end
      repeat (3) @(negedge clk);
      check({name, "_finish_once"}, 64'(fin_cnt - f0), 64'd1);
      check({name, "_rows_left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
`ifdef MEM_ROW_STREAMER_WRITE_BYPASS_EN
      bit bypass_on = 1;
`else
      bit bypass_on = 0;
`endif
      int f0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", out_data[63:0], 64'd0);
      check("rst_last", 64'(out_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_finish", 64'(finish), 64'd0);
      check("rst_addr", 64'(read_address), 64'd0);
      reset_n = 1;

      run_pass("p5x4", 20'd5, 20'd4);
      check("addr_hold", 64'(read_address), 64'd8);

      toggle_mode = 1;
      run_pass("stall", 20'd5, 20'd4);
      toggle_mode = 0;

      run_pass("len0", 20'd9, 20'd0);
      check("len0_busy", 64'(busy_seen), 64'd0);

      run_pass("wrap", 20'hFFFFE, 20'd3);

      push_exp(20'd0, 20'd6);
      f0 = fin_cnt;
      pulse_start(20'd0, 20'd6);
      @(posedge clk);
      #1;
      reset_n = 0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_data", out_data[63:0], 64'd0);
      check("mid_rst_last", 64'(out_last), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_finish", 64'(finish), 64'd0);
      check("mid_rst_addr", 64'(read_address), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;
      exp_q.delete();
      check("mid_rst_no_finish", 64'(fin_cnt - f0), 64'd0);
      run_pass("after_rst", 20'd0, 20'd1);

      bypass_mode = bypass_on;
      wr_arm = 1;
      run_pass("bypass", 20'd5, 20'd3);
      wr_arm = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
